adder_rs: RTL

ADDER_RS -- requirements
Module: adder_rs

---
 rtl/adder_rs.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/adder_rs.sv
// adder_rs: reservation station in front of a single add/subtract unit.
// Entries wait for operands on the CDB, the lowest-index ready entry is
// dispatched whenever the unit is idle, and an entry is freed when its
// own tag is broadcast on the CDB.
// Optional feature: define ADDER_RS_FLUSH_EN to add a 'flush' input that
// empties the station and idles the unit without touching fu_* data outputs.
module adder_rs #(
   parameter int ENTRIES  = 3,
   parameter int TAG_W    = 3,
   parameter int TAG_BASE = 1
) (
   input  logic             Clock,
   input  logic             Reset,
`ifdef ADDER_RS_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             issue_valid,
   input  logic             issue_op,
   input  logic [15:0]      issue_vj,
   input  logic [15:0]      issue_vk,
   input  logic [TAG_W-1:0] issue_qj,
   input  logic [TAG_W-1:0] issue_qk,
   output logic             issue_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [15:0]      cdb_data,
   output logic             fu_start,
   output logic             fu_op,
   output logic [15:0]      fu_reg1,
   output logic [15:0]      fu_reg2,
   output logic [TAG_W-1:0] fu_tag
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   typedef enum logic [1:0] {E_FREE, E_WAIT, E_READY, E_EXEC} ent_t;

   ent_t             st_q [ENTRIES];
   ent_t             st_d [ENTRIES];
   logic             op_q [ENTRIES];
   logic             op_d [ENTRIES];
   logic [15:0]      vj_q [ENTRIES];
   logic [15:0]      vj_d [ENTRIES];
   logic [15:0]      vk_q [ENTRIES];
   logic [15:0]      vk_d [ENTRIES];
   logic [TAG_W-1:0] qj_q [ENTRIES];
   logic [TAG_W-1:0] qj_d [ENTRIES];
   logic [TAG_W-1:0] qk_q [ENTRIES];
   logic [TAG_W-1:0] qk_d [ENTRIES];

   logic             fu_busy_q, fu_busy_d;
   logic             fu_start_d, fu_op_d;
   logic [15:0]      fu_reg1_d, fu_reg2_d;
   logic [TAG_W-1:0] fu_tag_d;

   logic             have_free, have_rdy;
   logic [IDX_W-1:0] alloc_idx, disp_idx;
   logic             cdb_hit;
   logic [15:0]      iss_vj, iss_vk;
   logic [TAG_W-1:0] iss_qj, iss_qk;

   function automatic logic [TAG_W-1:0] tag_of(input int unsigned i);
      return TAG_W'(TAG_BASE + i);
   endfunction

   // Lowest-index FREE entry for allocation, lowest-index READY entry for dispatch.
   always_comb begin
      have_free = 1'b0;
      alloc_idx = '0;
      have_rdy  = 1'b0;
      disp_idx  = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (!have_free && st_q[i] == E_FREE) begin
            have_free = 1'b1;
            alloc_idx = IDX_W'(i);
         end
         if (!have_rdy && st_q[i] == E_READY) begin
            have_rdy = 1'b1;
            disp_idx = IDX_W'(i);
         end
      end
   end

   assign issue_ready = have_free;
   assign alloc_tag   = have_free ? tag_of(32'(alloc_idx)) : TAG_W'(TAG_BASE);
   assign cdb_hit     = cdb_valid && (cdb_tag != '0);

   // Same-cycle CDB forwarding into the operands of an incoming issue.
   always_comb begin
      iss_vj = issue_vj;
      iss_qj = issue_qj;
      iss_vk = issue_vk;
      iss_qk = issue_qk;
      if (cdb_hit && issue_qj == cdb_tag) begin
         iss_vj = cdb_data;
         iss_qj = '0;
      end
      if (cdb_hit && issue_qk == cdb_tag) begin
         iss_vk = cdb_data;
         iss_qk = '0;
      end
   end

   // Next state: CDB wakeup/completion, dispatch, issue, then optional flush override.
   always_comb begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         st_d[i] = st_q[i];
         op_d[i] = op_q[i];
         vj_d[i] = vj_q[i];
         vk_d[i] = vk_q[i];
         qj_d[i] = qj_q[i];
         qk_d[i] = qk_q[i];
      end
      fu_busy_d  = fu_busy_q;
      fu_start_d = 1'b0;
      fu_op_d    = fu_op;
      fu_reg1_d  = fu_reg1;
      fu_reg2_d  = fu_reg2;
      fu_tag_d   = fu_tag;

      if (cdb_hit) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (st_q[i] == E_WAIT) begin
               if (qj_q[i] == cdb_tag) begin
                  vj_d[i] = cdb_data;
                  qj_d[i] = '0;
               end
               if (qk_q[i] == cdb_tag) begin
                  vk_d[i] = cdb_data;
                  qk_d[i] = '0;
               end
               if (qj_d[i] == '0 && qk_d[i] == '0)
                  st_d[i] = E_READY;
            end else if (st_q[i] == E_EXEC && cdb_tag == tag_of(i)) begin
               st_d[i]   = E_FREE;
               fu_busy_d = 1'b0;
            end
         end
      end

      // Busy is taken from the register, so a completion only enables the next edge.
      if (!fu_busy_q && have_rdy) begin
         st_d[disp_idx] = E_EXEC;
         fu_busy_d      = 1'b1;
         fu_start_d     = 1'b1;
         fu_op_d        = op_q[disp_idx];
         fu_reg1_d      = vj_q[disp_idx];
         fu_reg2_d      = vk_q[disp_idx];
         fu_tag_d       = tag_of(32'(disp_idx));
      end

      if (issue_valid && have_free) begin
         op_d[alloc_idx] = issue_op;
         vj_d[alloc_idx] = iss_vj;
         vk_d[alloc_idx] = iss_vk;
         qj_d[alloc_idx] = iss_qj;
         qk_d[alloc_idx] = iss_qk;
         st_d[alloc_idx] = (iss_qj == '0 && iss_qk == '0) ? E_READY : E_WAIT;
      end

`ifdef ADDER_RS_FLUSH_EN
      if (flush) begin
         for (int unsigned i = 0; i < ENTRIES; i++)
            st_d[i] = E_FREE;
         fu_busy_d  = 1'b0;
         fu_start_d = 1'b0;
         fu_op_d    = fu_op;
         fu_reg1_d  = fu_reg1;
         fu_reg2_d  = fu_reg2;
         fu_tag_d   = fu_tag;
      end
`endif
   end

   // State register with synchronous reset taking priority over everything.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            st_q[i] <= E_FREE;
            op_q[i] <= 1'b0;
            vj_q[i] <= '0;
            vk_q[i] <= '0;
            qj_q[i] <= '0;
            qk_q[i] <= '0;
         end
         fu_busy_q <= 1'b0;
         fu_start  <= 1'b0;
         fu_op     <= 1'b0;
         fu_reg1   <= '0;
         fu_reg2   <= '0;
         fu_tag    <= '0;
      end else begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            st_q[i] <= st_d[i];
            op_q[i] <= op_d[i];
            vj_q[i] <= vj_d[i];
            vk_q[i] <= vk_d[i];
            qj_q[i] <= qj_d[i];
            qk_q[i] <= qk_d[i];
         end
         fu_busy_q <= fu_busy_d;
         fu_start  <= fu_start_d;
         fu_op     <= fu_op_d;
         fu_reg1   <= fu_reg1_d;
         fu_reg2   <= fu_reg2_d;
         fu_tag    <= fu_tag_d;
      end
   end

endmodule
